// File: rtl/jtag_bridge_pkg.sv
// jtag_bridge_pkg: IR command codes and bridge FSM state encoding
package jtag_bridge_pkg;
  localparam logic [3:0] IR_CTRL   = 4'd0;
  localparam logic [3:0] IR_ADDR   = 4'd1;
  localparam logic [3:0] IR_WRITE  = 4'd2;
  localparam logic [3:0] IR_READ   = 4'd3;
  localparam logic [3:0] IR_STATUS = 4'd4;
  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ} state_t;
endpackage

// File: rtl/jtag_mem_bridge_if.sv
// jtag_mem_bridge_if: memory bus (req/we/addr/wdata out, ack/rdata in) with master/slave modports
interface jtag_mem_bridge_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;
  modport master(output mem_req, mem_we, mem_addr, mem_wdata, input mem_ack, mem_rdata);
  modport slave(input mem_req, mem_we, mem_addr, mem_wdata, output mem_ack, mem_rdata);
endinterface

// File: rtl/jtag_input_sync.sv
// jtag_input_sync: STAGES-deep synchronizer for tck plus WIDTH data bits (clk, rst, tck, d -> q, tck_rise)
module jtag_input_sync #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tck,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tck_rise
);
  logic [WIDTH:0] pipe [STAGES];
  logic           tck_prev;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) pipe[i] <= '0;
      tck_prev <= 1'b0;
    end else begin
      pipe[0] <= {d, tck};
      for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
      tck_prev <= pipe[STAGES-1][0];
    end
  end
  assign q        = pipe[STAGES-1][WIDTH:1];
  assign tck_rise = pipe[STAGES-1][0] & ~tck_prev;
endmodule

// File: rtl/jtag_mem_bridge.sv
// jtag_mem_bridge: JTAG virtual-DR to memory bridge (clk, reset, tck/tdi/tdo, ir_in, sdr/udr/uir, core_reset, mem master bus)
module jtag_mem_bridge import jtag_bridge_pkg::*; #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tck,
  input  logic                     tdi,
  output logic                     tdo,
  input  logic [3:0]               ir_in,
  input  logic                     virtual_state_sdr,
  input  logic                     virtual_state_udr,
  input  logic                     virtual_state_uir,
  output logic                     core_reset,
  jtag_mem_bridge_if.master        mem
);
  logic                  tck_rise, tdi_s, sdr_s, udr_s, uir_s;
  logic [3:0]            ir_in_s, ir;
  logic [DATA_WIDTH-1:0] dr, wdata;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  overrun, busy, upd, ack, mem_cmd;
  state_t                state, state_n;
  jtag_input_sync #(.STAGES(SYNC_STAGES), .WIDTH(8)) u_sync (
    .clk(clk),
    .rst(reset),
    .tck(tck),
    .d({virtual_state_uir, virtual_state_udr, virtual_state_sdr, ir_in, tdi}),
    .q({uir_s, udr_s, sdr_s, ir_in_s, tdi_s}),
    .tck_rise(tck_rise)
  );
  assign busy    = state != ST_IDLE;
  assign upd     = tck_rise & udr_s;
  assign ack     = busy & mem.mem_ack;
  assign mem_cmd = ir == IR_ADDR || ir == IR_WRITE || ir == IR_READ;
  always_ff @(posedge clk) state <= reset ? ST_IDLE : state_n;
  always_comb begin
    state_n = ack ? ST_IDLE
            : (!busy && upd && ir == IR_WRITE) ? ST_WRITE
            : (!busy && upd && ir == IR_READ) ? ST_READ
            : state;
  end
  always_comb begin
    mem.mem_req = busy;
    mem.mem_we  = state == ST_WRITE;
  end
  assign mem.mem_addr  = addr;
  assign mem.mem_wdata = wdata;
  assign tdo           = dr[0];
  always_ff @(posedge clk) begin
    if (reset) begin
      ir         <= '0;
      dr         <= '0;
      wdata      <= '0;
      addr       <= '0;
      overrun    <= 1'b0;
      core_reset <= 1'b1;
    end else begin
      if (tck_rise && uir_s) ir <= ir_in_s;
      if (ack && state == ST_READ) dr <= mem.mem_rdata;
      else if (upd && ir == IR_STATUS) dr <= DATA_WIDTH'({overrun, busy, core_reset});
      else if (tck_rise && sdr_s) dr <= {tdi_s, dr[DATA_WIDTH-1:1]};
      if (upd && ir == IR_CTRL) core_reset <= dr[0];
      if (upd && ir == IR_STATUS) overrun <= 1'b0;
      else if (upd && busy && mem_cmd) overrun <= 1'b1;
      if (ack) addr <= addr + ADDR_WIDTH'(DATA_WIDTH / 8);
      else if (upd && !busy && ir == IR_ADDR) addr <= dr[ADDR_WIDTH-1:0];
      if (upd && !busy && ir == IR_WRITE) wdata <= dr;
    end
  end
endmodule

// File: tb/tb_jtag_mem_bridge.sv
// tb_jtag_mem_bridge: self-checking bench for jtag_mem_bridge at 32- and 64-bit data widths
module tb_jtag_mem_bridge;
  import jtag_bridge_pkg::*;
  logic        clk = 0, reset = 1, tck = 0, tdi = 0, sdr = 0, udr = 0, uir = 0, sel = 0;
  logic [3:0]  ir_in = 0;
  logic        tdo32, tdo64, cr32, cr64, ack = 0;
  logic [63:0] rdata = 0;
  logic        tck32, tck64, req, we, tdo, core_rst;
  logic [31:0] maddr;
  logic [63:0] mwdata;
  int          checks = 0, failures = 0;
  bit          hold = 0, spur = 0;
  int          cnt = 0;
  typedef struct {logic we; logic [31:0] addr; logic [63:0] data;} txn_t;
  txn_t        log_q[$];
  txn_t        snap;
  typedef struct {logic [3:0] ir; logic [31:0] din; logic [31:0] rd; bit txn; logic we; logic [31:0] addr;} vec_t;
  vec_t        vecs[9];
  jtag_mem_bridge_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) m32();
  jtag_mem_bridge_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) m64();
  assign tck32          = tck & ~sel;
  assign tck64          = tck & sel;
  assign m32.mem_ack    = ack & ~sel;
  assign m64.mem_ack    = ack & sel;
  assign m32.mem_rdata  = rdata[31:0];
  assign m64.mem_rdata  = rdata;
  assign req            = sel ? m64.mem_req : m32.mem_req;
  assign we             = sel ? m64.mem_we : m32.mem_we;
  assign maddr          = sel ? m64.mem_addr : m32.mem_addr;
  assign mwdata         = sel ? m64.mem_wdata : {32'h0, m32.mem_wdata};
  assign tdo            = sel ? tdo64 : tdo32;
  assign core_rst       = sel ? cr64 : cr32;
  jtag_mem_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SYNC_STAGES(2)) dut32 (
    .clk(clk), .reset(reset), .tck(tck32), .tdi(tdi), .tdo(tdo32), .ir_in(ir_in),
    .virtual_state_sdr(sdr), .virtual_state_udr(udr), .virtual_state_uir(uir),
    .core_reset(cr32), .mem(m32));
  jtag_mem_bridge #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .SYNC_STAGES(3)) dut64 (
    .clk(clk), .reset(reset), .tck(tck64), .tdi(tdi), .tdo(tdo64), .ir_in(ir_in),
    .virtual_state_sdr(sdr), .virtual_state_udr(udr), .virtual_state_uir(uir),
    .core_reset(cr64), .mem(m64));
  always #5 clk = ~clk;
  initial begin
    #900us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // memory slave: 3 stall cycles then ack, request must hold steady meanwhile
  initial forever begin
    @(negedge clk);
    ack = 0;
    if (spur) begin
      ack  = 1;
      spur = 0;
    end else if (!req || hold) cnt = 0;
    else if (cnt == 0) begin
      snap = '{we, maddr, mwdata};
      cnt  = 1;
    end else begin
      chk("req_stable", {we, maddr, mwdata}, {snap.we, snap.addr, snap.data});
      if (cnt < 3) cnt++;
      else begin
        ack = 1;
        log_q.push_back(snap);
        cnt = 0;
      end
    end
  end
  task automatic tck_pulse(input logic b);
    tdi = b;
    repeat (4) @(negedge clk);
    tck = 1;
    repeat (4) @(negedge clk);
    tck = 0;
  endtask
  task automatic scan_dr(input logic [63:0] din, output logic [63:0] dout);
    int n = sel ? 64 : 32;
    dout = 0;
    sdr  = 1;
    for (int i = 0; i < n; i++) begin
      dout[i] = tdo;
      tck_pulse(din[i]);
    end
    sdr = 0;
  endtask
  task automatic cmd(input logic [3:0] ir, input logic [63:0] din);
    logic [63:0] junk;
    ir_in = ir;
    uir   = 1;
    tck_pulse(0);
    uir = 0;
    scan_dr(din, junk);
    udr = 1;
    tck_pulse(0);
    udr = 0;
  endtask
  task automatic wait_idle(input string name);
    int n = 0;
    while (req && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_timeout"}, req, 0);
    repeat (2) @(negedge clk);
  endtask
  task automatic expect_txn(input string name, input logic w, input logic [31:0] a, input logic [63:0] d);
    txn_t t;
    chk({name, "_count"}, log_q.size(), 1);
    if (log_q.size() > 0) begin
      t = log_q.pop_front();
      chk({name, "_we"}, t.we, w);
      chk({name, "_addr"}, t.addr, a);
      if (w) chk({name, "_wdata"}, t.data, d);
    end
  endtask
  initial begin
    logic [63:0] d, v, rd;
    logic [31:0] addr_m;
    logic        core_m;
    int          op;
    vecs = '{
      '{IR_ADDR,  32'h00001000, 32'h0,        0, 0, 32'h0},
      '{IR_WRITE, 32'hDEADBEEF, 32'h0,        1, 1, 32'h00001000},
      '{IR_WRITE, 32'h12345678, 32'h0,        1, 1, 32'h00001004},
      '{IR_ADDR,  32'h00002000, 32'h0,        0, 0, 32'h0},
      '{IR_READ,  32'h0,        32'hCAFEF00D, 1, 0, 32'h00002000},
      '{IR_WRITE, 32'h0BADF00D, 32'h0,        1, 1, 32'h00002004},
      '{IR_ADDR,  32'hFFFFFFFC, 32'h0,        0, 0, 32'h0},
      '{IR_WRITE, 32'h11111111, 32'h0,        1, 1, 32'hFFFFFFFC},
      '{IR_WRITE, 32'h22222222, 32'h0,        1, 1, 32'h00000000}
    };
    repeat (3) @(negedge clk);
    chk("rst_core_reset32", cr32, 1);
    chk("rst_core_reset64", cr64, 1);
    chk("rst_mem_req", req, 0);
    chk("rst_tdo", tdo32, 0);
    reset = 0;
    repeat (2) @(negedge clk);
    cmd(IR_CTRL, 0);
    chk("ctrl_clear", core_rst, 0);
    spur = 1;
    repeat (3) @(negedge clk);
    cmd(IR_WRITE, 64'hA5A5A5A5);
    wait_idle("spur");
    expect_txn("spur_ignored", 1, 32'h0, 64'hA5A5A5A5);
    for (int i = 0; i < 9; i++) begin
      string nm = $sformatf("vec%0d", i);
      rdata = {32'h0, vecs[i].rd};
      cmd(vecs[i].ir, {32'h0, vecs[i].din});
      wait_idle(nm);
      if (vecs[i].txn) expect_txn(nm, vecs[i].we, vecs[i].addr, {32'h0, vecs[i].din});
      else chk({nm, "_no_txn"}, log_q.size(), 0);
      if (vecs[i].ir == IR_READ) begin
        scan_dr(0, d);
        chk({nm, "_readback"}, d[31:0], vecs[i].rd);
      end
    end
    addr_m = 32'h4;
    core_m = 0;
    for (int i = 0; i < 24; i++) begin
      string nm = $sformatf("rnd%0d", i);
      op = $urandom_range(0, 4);
      v  = {32'h0, $urandom};
      if (op == 0) begin
        cmd(IR_ADDR, v);
        addr_m = v[31:0];
        chk({nm, "_addr_no_txn"}, log_q.size(), 0);
      end else if (op == 1) begin
        cmd(IR_WRITE, v);
        wait_idle(nm);
        expect_txn(nm, 1, addr_m, v);
        addr_m = addr_m + 4;
      end else if (op == 2) begin
        rd    = {32'h0, $urandom};
        rdata = rd;
        cmd(IR_READ, v);
        wait_idle(nm);
        expect_txn(nm, 0, addr_m, 0);
        addr_m = addr_m + 4;
        scan_dr(0, d);
        chk({nm, "_readback"}, d, rd);
      end else if (op == 3) begin
        cmd(IR_CTRL, v);
        core_m = v[0];
        chk({nm, "_core_reset"}, core_rst, core_m);
      end else begin
        cmd(IR_STATUS, v);
        scan_dr(0, d);
        chk({nm, "_status"}, d, {63'h0, core_m});
      end
    end
    cmd(IR_CTRL, 0);
    cmd(IR_ADDR, 64'h3000);
    hold = 1;
    cmd(IR_WRITE, 64'hAAAA0001);
    chk("ovr_req_held", req, 1);
    cmd(IR_WRITE, 64'hBBBB0002);
    cmd(IR_STATUS, 0);
    scan_dr(0, d);
    chk("ovr_status_busy", d, 64'h6);
    cmd(IR_CTRL, 1);
    chk("ovr_core_set", core_rst, 1);
    chk("ovr_req_not_aborted", req, 1);
    cmd(IR_CTRL, 0);
    hold = 0;
    wait_idle("ovr");
    expect_txn("ovr_first_only", 1, 32'h3000, 64'hAAAA0001);
    cmd(IR_STATUS, 0);
    scan_dr(0, d);
    chk("ovr_status_clear", d, 64'h0);
    hold = 1;
    cmd(IR_WRITE, 64'hC0C0C0C0);
    chk("mid_req_high", req, 1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("mid_req_dropped", req, 0);
    chk("mid_core_reset", core_rst, 1);
    hold = 0;
    spur = 1;
    repeat (10) @(negedge clk);
    chk("mid_no_txn", log_q.size(), 0);
    chk("mid_req_low", req, 0);
    cmd(IR_CTRL, 0);
    cmd(IR_WRITE, 64'hD00DD00D);
    wait_idle("mid");
    expect_txn("mid_after", 1, 32'h0, 64'hD00DD00D);
    sel = 1;
    repeat (4) @(negedge clk);
    cmd(IR_WRITE, 64'h0123456789ABCDEF);
    wait_idle("w64a");
    expect_txn("w64a", 1, 32'h0, 64'h0123456789ABCDEF);
    cmd(IR_WRITE, 64'hFEDCBA9876543210);
    wait_idle("w64b");
    expect_txn("w64b", 1, 32'h8, 64'hFEDCBA9876543210);
    rd    = {$urandom, $urandom};
    rdata = rd;
    cmd(IR_READ, 0);
    wait_idle("r64");
    expect_txn("r64", 0, 32'h10, 0);
    scan_dr(0, d);
    chk("r64_readback", d, rd);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
